// File: rtl/fpu_special_case_ctrl_64_pkg.sv
// Shared types and constants for the FPU special-case sequencer.
// Operation codes, IEEE-754 double patterns and FSM state encoding.
package fpu_special_case_ctrl_64_pkg;

  localparam logic [1:0] OP_ADDSUB = 2'b00;
  localparam logic [1:0] OP_UNARY  = 2'b01;
  localparam logic [1:0] OP_MULT   = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [63:0] POS_INF  = 64'h7ff0000000000000;
  localparam logic [63:0] NEG_INF  = 64'hfff0000000000000;
  localparam logic [63:0] POS_ZERO = 64'h0000000000000000;
  localparam logic [63:0] QNAN     = 64'h7ff8000000000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT_CORE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/special_case_detect_64.sv
// Combinational classifier for invalid-operation operand combinations.
// Only exact +inf/-inf and +0 patterns are considered special.
module special_case_detect_64
  import fpu_special_case_ctrl_64_pkg::*;
(
  input  logic [1:0]  operation,
  input  logic [63:0] data1,
  input  logic [63:0] data2,
  output logic        invalid
);

  logic d1_inf;
  logic d2_inf;
  logic d1_zero;
  logic d2_zero;

  assign d1_inf  = (data1 == POS_INF) || (data1 == NEG_INF);
  assign d2_inf  = (data2 == POS_INF) || (data2 == NEG_INF);
  assign d1_zero = (data1 == POS_ZERO);
  assign d2_zero = (data2 == POS_ZERO);

  always_comb begin
    invalid = 1'b0;
    unique case (1'b1)
      (operation == OP_ADDSUB):
        invalid = d1_inf && d2_inf;
      (operation == OP_UNARY):
        invalid = d1_inf;
      (operation == OP_MULT):
        invalid = (d1_zero && d2_inf) ||
                  (d2_zero && d1_inf);
      default:
        invalid = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_special_case_ctrl_64.sv
// Sequencer in front of the 64-bit FP core: screens invalid operands,
// launches the core, guards it with a timeout, holds result until ack.
module fpu_special_case_ctrl_64 #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [63:0] QNAN = 64'h7ff8000000000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  operation,
  input  logic [63:0] data1,
  input  logic [63:0] data2,
  output logic        busy,
  output logic        core_start,
  input  logic        core_done,
  input  logic [63:0] core_result,
  input  logic        core_overflow,
  input  logic        core_underflow,
  output logic        result_valid,
  output logic [63:0] result,
  output logic        NaN_flag,
  output logic        overflow_flag,
  output logic        underflow_flag,
  output logic        timeout_flag,
  input  logic        ack
);

  import fpu_special_case_ctrl_64_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    op_q;
  logic [63:0]   d1_q;
  logic [63:0]   d2_q;
  logic [CW-1:0] cnt;
  logic          invalid;
  logic          launch;
  logic          expired;

  special_case_detect_64 u_detect (
    .operation (op_q),
    .data1     (d1_q),
    .data2     (d2_q),
    .invalid   (invalid)
  );

  assign launch  = !invalid && (op_q != OP_RSVD);
  assign expired = (cnt == CNT_LAST);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (start) state_nxt = ST_CHECK;
      ST_CHECK:
        state_nxt = launch ? ST_WAIT_CORE : ST_DONE;
      ST_WAIT_CORE:
        if (core_done || expired) state_nxt = ST_DONE;
      ST_DONE:
        if (result_valid && ack) state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Outputs lag the state by one edge, so ack counts only once valid is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= '0;
      d1_q           <= '0;
      d2_q           <= '0;
      cnt            <= '0;
      core_start     <= 1'b0;
      result_valid   <= 1'b0;
      result         <= '0;
      NaN_flag       <= 1'b0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
      timeout_flag   <= 1'b0;
    end else begin
      core_start   <= (state == ST_WAIT_CORE) &&
                      (cnt == '0) && !core_done;
      result_valid <= (state == ST_DONE) &&
                      !(result_valid && ack);
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= operation;
            d1_q <= data1;
            d2_q <= data2;
          end
        end
        ST_CHECK: begin
          cnt <= '0;
          if (!launch) begin
            result         <= invalid ? QNAN : '0;
            NaN_flag       <= invalid;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            timeout_flag   <= 1'b0;
          end
        end
        ST_WAIT_CORE: begin
          cnt <= cnt + 1'b1;
          if (core_done) begin
            result         <= core_result;
            NaN_flag       <= 1'b0;
            overflow_flag  <= core_overflow;
            underflow_flag <= core_underflow;
            timeout_flag   <= 1'b0;
          end else if (expired) begin
            result         <= QNAN;
            NaN_flag       <= 1'b1;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            timeout_flag   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
